serial_sub_ctrl: RTL and testbench

Bit-serial subtraction controller that sequences one external 1-bit full subtractor (fsub) over WIDTH-bit operands, LSB first, one bit per clock. It latches the operands on a start pulse and feeds each bit plus the running borrow to the fsub. It collects the fsub outputs into a difference register and reports completion with a one-cycle done pulse. It sits between a requesting block and a single shared fsub slice.

---
 rtl/serial_sub_ctrl.sv | 146 ++++++++++++++
 tb/tb_serial_sub_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// ============================================================================
//  Module   : serial_sub_ctrl
//  Brief    : Bit-serial subtraction sequencer for one shared 1-bit full
//             subtractor, LSB first, one bit per clock.
//             Optional signed-overflow output enabled by macro SUB_OVF_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin_in,
    output logic             fs_a,
    output logic             fs_b,
    output logic             fs_bin,
    input  logic             fs_d,
    input  logic             fs_bout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int                 c_IDX_W = $clog2(WIDTH);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic [WIDTH-1:0]   r_diff;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_borrow;
    logic               r_bout;
    logic               w_accept;
    logic               w_last;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_idx == c_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        fs_a        = 1'b0;
        fs_b        = 1'b0;
        fs_bin      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                fs_a   = r_x[r_idx];
                fs_b   = r_y[r_idx];
                fs_bin = r_borrow;
                busy   = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: the fsub is combinational, so its outputs are captured on the
    // same edge that advances the bit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_diff   <= '0;
            r_idx    <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
        end else if (w_accept) begin
            r_x      <= x;
            r_y      <= y;
            r_borrow <= bin_in;
            r_idx    <= '0;
            r_diff   <= '0;
        end else if (r_state == S_RUN) begin
            r_diff[r_idx] <= fs_d;
            r_borrow      <= fs_bout;
            if (w_last) begin
                r_bout <= fs_bout;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

`ifdef SUB_OVF_EN
    logic r_ovf;

    // Signed overflow: operand signs differ and the result sign differs from x.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_ovf <= (r_x[WIDTH-1] != r_y[WIDTH-1]) && (fs_d != r_x[WIDTH-1]);
        end
    end

    assign ovf = r_ovf;
`endif

    assign diff = r_diff;
    assign bout = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
// ============================================================================
//  Module   : tb_serial_sub_ctrl
//  Brief    : Directed self-checking bench for serial_sub_ctrl (WIDTH=8),
//             with a behavioural 1-bit full subtractor on the fsub port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_sub_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             bin_in;
    logic             fs_a;
    logic             fs_b;
    logic             fs_bin;
    logic             fs_d;
    logic             fs_bout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x       (x),
        .y       (y),
        .bin_in  (bin_in),
        .fs_a    (fs_a),
        .fs_b    (fs_b),
        .fs_bin  (fs_bin),
        .fs_d    (fs_d),
        .fs_bout (fs_bout),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
`ifdef SUB_OVF_EN
        .ovf     (ovf),
`endif
        .bout    (bout)
    );

    // External full subtractor: a - b - bin
    assign fs_d    = fs_a ^ fs_b ^ fs_bin;
    assign fs_bout = (~fs_a & fs_b) | (~(fs_a ^ fs_b) & fs_bin);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle start and wait (bounded) for done; lat counts edges after E0.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                          output int lat);
        x      = a;
        y      = b;
        bin_in = bi;
        start  = 1'b1;
        step();
        start  = 1'b0;
        lat    = 0;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
    endtask

    int          lat;
    int          first_done;
    int          second_done;
    logic [7:0]  pat;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        x      = '0;
        y      = '0;
        bin_in = 1'b0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        chk("rst_fs", {fs_a, fs_b, fs_bin}, 0);
        rst = 1'b0;
        step();

        // 0x5A - 0x3C: watch the minuend bit stream on fs_a
        pat    = 8'b0101_1010;
        x      = 8'h5A;
        y      = 8'h3C;
        bin_in = 1'b0;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            chk($sformatf("fs_a_bit%0d", k), fs_a, pat[k]);
            chk($sformatf("no_done_%0d", k), done, 0);
            step();
        end
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 1);
        chk("t1_diff", diff, 8'h1E);
        chk("t1_bout", bout, 0);
        step();
        chk("t1_done_pulse", done, 0);
        chk("t1_idle_busy", busy, 0);

        run_op(8'h00, 8'h01, 1'b0, lat);
        chk("t2_lat", lat, WIDTH);
        chk("t2_diff", diff, 8'hFF);
        chk("t2_bout", bout, 1);
        step();
        step();
        step();
        chk("t2_hold_diff", diff, 8'hFF);
        chk("t2_hold_bout", bout, 1);
        chk("t2_idle_fs", {fs_a, fs_b, fs_bin}, 0);

        run_op(8'h10, 8'h0F, 1'b1, lat);
        chk("t3_diff", diff, 8'h00);
        chk("t3_bout", bout, 0);
        step();
        run_op(8'h00, 8'h00, 1'b1, lat);
        chk("t4_diff", diff, 8'hFF);
        chk("t4_bout", bout, 1);
        step();

        // start issued mid-run with new operands must be ignored
        x      = 8'h5A;
        y      = 8'h3C;
        bin_in = 1'b0;
        start  = 1'b1;
        step();
        start  = 1'b0;
        step();
        step();
        step();
        x     = 8'h33;
        start = 1'b1;
        step();
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        chk("t5_done_seen", done, 1);
        chk("t5_diff", diff, 8'h1E);
        step();
        chk("t5_idle", busy, 0);

        // continuous start: done pulses spaced WIDTH+2 apart
        x           = 8'h5A;
        y           = 8'h3C;
        start       = 1'b1;
        first_done  = -1;
        second_done = -1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (done && first_done < 0) begin
                first_done = c;
            end else if (done && second_done < 0) begin
                second_done = c;
            end
        end
        start = 1'b0;
        chk("t6_spacing", second_done - first_done, WIDTH + 2);
        chk("t6_diff", diff, 8'h1E);
        lat = 0;
        while (busy && lat < 40) begin
            step();
            lat++;
        end
        chk("t6_idle", busy, 0);

        // asynchronous reset in the middle of a run (idx=4)
        x      = 8'h5A;
        y      = 8'h3C;
        bin_in = 1'b0;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("t7_pre_fs_a", fs_a, 1);
        chk("t7_pre_diff", diff, 8'h0E);
        #2;
        rst = 1'b1;
        #1;
        chk("t7_busy", busy, 0);
        chk("t7_done", done, 0);
        chk("t7_diff", diff, 0);
        chk("t7_bout", bout, 0);
        chk("t7_fs", {fs_a, fs_b, fs_bin}, 0);
        step();
        rst = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            step();
            chk($sformatf("t7_no_done_%0d", k), done, 0);
        end
        run_op(8'h5A, 8'h3C, 1'b0, lat);
        chk("t7_after_lat", lat, WIDTH);
        chk("t7_after_diff", diff, 8'h1E);
        step();

`ifdef SUB_OVF_EN
        run_op(8'h80, 8'h01, 1'b0, lat);
        chk("ovf1_diff", diff, 8'h7F);
        chk("ovf1_ovf", ovf, 1);
        step();
        chk("ovf1_hold", ovf, 1);
        x     = 8'h05;
        y     = 8'h03;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ovf_clear", ovf, 0);
        lat = 0;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        chk("ovf2_diff", diff, 8'h02);
        chk("ovf2_ovf", ovf, 0);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
